// File: rtl/mips_store_unit.sv
// Store-side memory unit: turns SB/SH/SW/SWL/SWR into one Avalon-MM write with byte enables and a waitrequest timeout.
// Optional MIPS_STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW instead of silently aligning them.
module mips_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  store_op,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        done,
    output logic        error,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken on a rising edge where req_valid and req_ready are both high;
    // the write completes on a rising edge where avm_write is high and avm_waitrequest is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wd;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_ea;
    logic [3:0]       w_be;
    logic [31:0]      w_wd;
    logic             w_bad;
    logic             w_timeout;

    assign w_ea = base + offset;

    always_comb begin
        w_be  = 4'b0000;
        w_wd  = 32'h0;
        w_bad = 1'b0;
        case (store_op)
            3'd0: begin
                w_be = 4'b0001 << w_ea[1:0];
                w_wd = {4{store_data[7:0]}};
            end
            3'd1: begin
                w_be = w_ea[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{store_data[15:0]}};
            end
            3'd2: begin
                w_be = 4'b1111;
                w_wd = store_data;
            end
            // 3-k equals ~k for a two-bit lane index
            3'd3: begin
                w_be = 4'b1111 >> ~w_ea[1:0];
                w_wd = store_data >> {~w_ea[1:0], 3'b000};
            end
            3'd4: begin
                w_be = 4'b1111 << w_ea[1:0];
                w_wd = store_data << {w_ea[1:0], 3'b000};
            end
            default: w_bad = 1'b1;
        endcase
`ifdef MIPS_STORE_MISALIGN_TRAP_EN
        if ((store_op == 3'd1 && w_ea[0]) || (store_op == 3'd2 && w_ea[1:0] != 2'b00)) begin
            w_bad = 1'b1;
        end
`endif
    end

    assign w_timeout = TO_EN && avm_waitrequest && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        avm_write = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_bad ? RESP : WRITE;
                end
            end
            WRITE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                done   = 1'b1;
                error  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 32'h0;
            r_be   <= 4'b0000;
            r_wd   <= 32'h0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr <= {w_ea[31:2], 2'b00};
                        r_be   <= w_be;
                        r_wd   <= w_wd;
                        r_err  <= w_bad;
                    end
                end
                WRITE: begin
                    if (avm_waitrequest) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RESP: r_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign avm_address    = r_addr;
    assign avm_writedata  = r_wd;
    assign avm_byteenable = r_be;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_mips_store_unit.sv
// Directed bench for mips_store_unit: per-byte memory-view model, per-cycle bus compare, latency checks.
module tb_mips_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  store_op;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic        done;
    logic        error;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic        exp_err;

    mips_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .store_op(store_op), .base(base), .offset(offset), .store_data(store_data),
        .done(done), .error(error), .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Memory-view model: decide, byte by byte, which register byte lands in each lane.
    function automatic void model(input logic [2:0] op, input logic [31:0] b, input logic [31:0] o,
                                  input logic [31:0] rt, output logic [31:0] addr,
                                  output logic [3:0] be, output logic [31:0] wd, output logic bad);
        logic [31:0] ea;
        logic [7:0]  rb [4];
        int k;
        ea   = b + o;
        k    = int'(ea[1:0]);
        addr = ea & 32'hFFFF_FFFC;
        be   = 4'b0000;
        wd   = 32'h0;
        bad  = 1'b0;
        for (int j = 0; j < 4; j++) rb[j] = rt[8*j +: 8];
        for (int j = 0; j < 4; j++) begin
            case (op)
                3'd0: begin wd[8*j +: 8] = rb[0]; be[j] = (j == k); end
                3'd1: begin wd[8*j +: 8] = rb[j % 2]; be[j] = ((j / 2) == int'(ea[1])); end
                3'd2: begin wd[8*j +: 8] = rb[j]; be[j] = 1'b1; end
                3'd3: if (j <= k) begin wd[8*j +: 8] = rb[3 - k + j]; be[j] = 1'b1; end
                3'd4: if (j >= k) begin wd[8*j +: 8] = rb[j - k]; be[j] = 1'b1; end
                default: bad = 1'b1;
            endcase
        end
`ifdef MIPS_STORE_MISALIGN_TRAP_EN
        if ((op == 3'd1 && ea[0]) || (op == 3'd2 && k != 0)) bad = 1'b1;
`endif
    endfunction

    // Bus and response compare, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (avm_write) begin
                check("bus_addr", avm_address, m_addr);
                check("bus_be", {28'h0, avm_byteenable}, {28'h0, m_be});
                check("bus_wd", avm_writedata, m_wd);
            end
            if (done) check("resp_error", {31'h0, error}, {31'h0, exp_err});
            else      check("error_without_done", {31'h0, error}, 32'h0);
        end
    end

    task automatic run_store(input string name, input logic [2:0] op, input logic [31:0] b,
                             input logic [31:0] o, input logic [31:0] rt, input int stall);
        logic bad;
        int wr;
        int done_idx;
        int exp_wr;
        model(op, b, o, rt, m_addr, m_be, m_wd, bad);
        exp_err = bad || (stall >= TO);
        exp_wr  = bad ? 0 : ((stall >= TO) ? TO : stall + 1);
        @(negedge clk);
        store_op = op; base = b; offset = o; store_data = rt; req_valid = 1'b1;
        check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        store_op = 3'($urandom_range(0, 7)); base = $urandom; offset = $urandom; store_data = $urandom;
        wr = 0;
        done_idx = 0;
        for (int c = 1; c <= 60 && done_idx == 0; c++) begin
            @(negedge clk);
            if (avm_write) begin
                wr++;
                avm_waitrequest = (wr <= stall);
            end
            if (done) done_idx = c;
        end
        avm_waitrequest = 1'b0;
        check({name, "_write_cycles"}, wr, exp_wr);
        check({name, "_done_latency"}, done_idx, exp_wr + 1);
        @(negedge clk);
        check({name, "_single_done"}, {31'h0, done}, 32'h0);
        check({name, "_ready_back"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic pin_model(input string name, input logic [2:0] op, input logic [31:0] b,
                             input logic [31:0] o, input logic [31:0] rt, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd_mask, input logic [31:0] wd);
        logic [31:0] a_m;
        logic [3:0]  be_m;
        logic [31:0] wd_m;
        logic        bad_m;
        model(op, b, o, rt, a_m, be_m, wd_m, bad_m);
        check({name, "_addr"}, a_m, addr);
        check({name, "_be"}, {28'h0, be_m}, {28'h0, be});
        check({name, "_wd"}, wd_m & wd_mask, wd);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; store_op = 3'd0; base = 32'h0; offset = 32'h0;
        store_data = 32'h0; avm_waitrequest = 1'b0;
        exp_err = 1'b0; m_addr = 32'h0; m_be = 4'b0; m_wd = 32'h0;

        pin_model("pin_sb", 3'd0, 32'h1000, 32'd3, 32'h0000_00AB, 32'h1000, 4'b1000, 32'hFF00_0000, 32'hAB00_0000);
        pin_model("pin_swl", 3'd3, 32'h2000, 32'd1, 32'h1122_3344, 32'h2000, 4'b0011, 32'h0000_FFFF, 32'h0000_1122);
        pin_model("pin_swr", 3'd4, 32'h2000, 32'd1, 32'h1122_3344, 32'h2000, 4'b1110, 32'hFFFF_FF00, 32'h2233_4400);
        pin_model("pin_sh", 3'd1, 32'h2000, 32'd2, 32'h0000_BEEF, 32'h2000, 4'b1100, 32'hFFFF_FFFF, 32'hBEEF_BEEF);
        pin_model("pin_sw", 3'd2, 32'h1000, 32'd2, 32'hCAFE_F00D, 32'h1000, 4'b1111, 32'hFFFF_FFFF, 32'hCAFE_F00D);

        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_write", {31'h0, avm_write}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_addr", avm_address, 32'h0);
        check("rst_be", {28'h0, avm_byteenable}, 32'h0);
        check("rst_wd", avm_writedata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_store("sb_k3", 3'd0, 32'h1000, 32'd3, 32'h0000_00AB, 0);
        run_store("swl_k1", 3'd3, 32'h2000, 32'd1, 32'h1122_3344, 0);
        run_store("swr_k1", 3'd4, 32'h2000, 32'd1, 32'h1122_3344, 0);
        run_store("sw_wait3", 3'd2, 32'h4000, 32'd8, 32'hDEAD_BEEF, 3);
        run_store("sw_timeout", 3'd2, 32'h4100, 32'd0, 32'h0BAD_0BAD, 1000);
        run_store("illegal6", 3'd6, 32'h5000, 32'd0, 32'h1234_5678, 0);
        run_store("illegal5", 3'd5, 32'h5000, 32'd4, 32'h1234_5678, 0);
        run_store("illegal7", 3'd7, 32'h5000, 32'd8, 32'h1234_5678, 0);
        run_store("sw_mis", 3'd2, 32'h1000, 32'd2, 32'hCAFE_F00D, 0);
        run_store("sh_neg_off", 3'd1, 32'h1010, 32'hFFFF_FFF6, 32'hCAFE_BABE, 0);
        run_store("sh_odd", 3'd1, 32'h2000, 32'd3, 32'h0000_A55A, 1);
        run_store("sb_wrap", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0077, 0);
        run_store("swl_k3", 3'd3, 32'h3000, 32'd3, 32'h8899_AABB, 0);
        run_store("swl_k0", 3'd3, 32'h3000, 32'd0, 32'h8899_AABB, 2);
        run_store("swr_k0", 3'd4, 32'h3000, 32'd0, 32'h8899_AABB, 0);
        run_store("swr_k3", 3'd4, 32'h3000, 32'd3, 32'h8899_AABB, 0);

        // Reset while a write is stalled: bus strobe must drop at once and no done may follow.
        model(3'd2, 32'h3000, 32'd4, 32'h0F0F_0F0F, m_addr, m_be, m_wd, exp_err);
        @(negedge clk);
        store_op = 3'd2; base = 32'h3000; offset = 32'd4; store_data = 32'h0F0F_0F0F; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        avm_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_write", {31'h0, avm_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", {31'h0, avm_write}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("in_rst_done", {31'h0, done}, 32'h0);
        end
        avm_waitrequest = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", {31'h0, done}, 32'h0);
        run_store("sh_after_rst", 3'd1, 32'h2000, 32'd2, 32'h0000_1357, 0);
        check("sh_after_rst_be", {28'h0, m_be}, {28'h0, 4'b1100});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
